// File: rtl/gen1_8b10b_encode.sv
// gen1_8b10b_encode: 4-lane 8b/10b transmit encoder for the PIPE TX path.
// Ports:
//   clk_i, rst_ni      PCLK and asynchronous active-low reset
//   data_in_i[31:0]    scrambled bytes, byte n = [8n+7:8n], byte 0 first in time
//   data_k_in_i[3:0]   per-byte control flag
//   data_valid_i       beat qualifier
//   pipe_width_i[5:0]  8 -> 1 lane, 16 -> 2 lanes, anything else -> 4 lanes
//   data_valid_o       registered beat qualifier
//   symbols_o[39:0]    symbol n = [10n+9:10n], bit 0 = code bit a, bit 9 = j
//   disparity_o        running disparity after the last encoded byte (1 = RD+)
//   code_err_o         illegal K code seen in the output beat
// Option: GEN1_8B10B_KCHECK_EN enables code_err_o; otherwise it is tied to 0.
module gen1_8b10b_encode (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_in_i,
    input  logic [3:0]  data_k_in_i,
    input  logic        data_valid_i,
    input  logic [5:0]  pipe_width_i,
    output logic        data_valid_o,
    output logic [39:0] symbols_o,
    output logic        disparity_o,
    output logic        code_err_o
);
    function automatic logic k_legal(input logic [7:0] b);
        return b[4:0] == 5'd28 || b == 8'hF7 || b == 8'hFB || b == 8'hFD || b == 8'hFE;
    endfunction

    // Returns {rd_out, symbol}; symbol bit 0 is code bit a.
    function automatic logic [10:0] enc_byte(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       kv, k28, a7, alt_k, rd1, rd2;
        logic [5:0] b6, c6;
        logic [3:0] b4, c4;
        logic [9:0] s, r;
        x = b[4:0];
        y = b[7:5];
        kv = k && k_legal(b);
        k28 = kv && x == 5'd28;
        case (x)
            5'd0:  b6 = 6'b100111;
            5'd1:  b6 = 6'b011101;
            5'd2:  b6 = 6'b101101;
            5'd3:  b6 = 6'b110001;
            5'd4:  b6 = 6'b110101;
            5'd5:  b6 = 6'b101001;
            5'd6:  b6 = 6'b011001;
            5'd7:  b6 = 6'b111000;
            5'd8:  b6 = 6'b111001;
            5'd9:  b6 = 6'b100101;
            5'd10: b6 = 6'b010101;
            5'd11: b6 = 6'b110100;
            5'd12: b6 = 6'b001101;
            5'd13: b6 = 6'b101100;
            5'd14: b6 = 6'b011100;
            5'd15: b6 = 6'b010111;
            5'd16: b6 = 6'b011011;
            5'd17: b6 = 6'b100011;
            5'd18: b6 = 6'b010011;
            5'd19: b6 = 6'b110010;
            5'd20: b6 = 6'b001011;
            5'd21: b6 = 6'b101010;
            5'd22: b6 = 6'b011010;
            5'd23: b6 = 6'b111010;
            5'd24: b6 = 6'b110011;
            5'd25: b6 = 6'b100110;
            5'd26: b6 = 6'b010110;
            5'd27: b6 = 6'b110110;
            5'd28: b6 = k28 ? 6'b001111 : 6'b001110;
            5'd29: b6 = 6'b101110;
            5'd30: b6 = 6'b011110;
            default: b6 = 6'b101011;
        endcase
        // Tables hold the RD- form; RD+ is the complement for unbalanced codes
        // and for the balanced-but-polarised D.7 (111000/000111).
        c6 = (rd && ($countones(b6) != 3 || (x == 5'd7 && !k28))) ? ~b6 : b6;
        rd1 = rd ^ ($countones(b6) != 3);
        case (y)
            3'd0:    b4 = 4'b1011;
            3'd1:    b4 = 4'b1001;
            3'd2:    b4 = 4'b0101;
            3'd3:    b4 = 4'b1100;
            3'd4:    b4 = 4'b1101;
            3'd5:    b4 = 4'b1010;
            3'd6:    b4 = 4'b0110;
            default: b4 = 4'b1110;
        endcase
        // Alternate x.7 avoids a run of five equal bits across the sub-block seam.
        a7 = y == 3'd7 && (kv || (!rd1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (rd1 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (a7)
            b4 = 4'b0111;
        // K28.1/.2/.5/.6 use the balanced 4b codes in the opposite polarity to D.
        alt_k = k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6);
        c4 = alt_k ? (rd1 ? b4 : ~b4) :
             ((rd1 && ($countones(b4) != 2 || y == 3'd3)) ? ~b4 : b4);
        rd2 = rd1 ^ ($countones(b4) != 2);
        s = {c6, c4};
        for (int i = 0; i < 10; i++)
            r[i] = s[9 - i];
        return {rd2, r};
    endfunction

    logic [3:0]  w_act;
    logic [39:0] w_sym;
    logic        w_rd;
    logic [39:0] r_sym;
    logic        r_valid;
    logic        r_rd;

    assign w_act = pipe_width_i == 6'd8 ? 4'b0001 : pipe_width_i == 6'd16 ? 4'b0011 : 4'b1111;

    // Disparity ripples through the active lanes in time order within one cycle.
    always_comb begin
        logic        rd;
        logic [10:0] e;
        rd = r_rd;
        e = '0;
        w_sym = '0;
        for (int n = 0; n < 4; n++) begin
            if (w_act[n]) begin
                e = enc_byte(data_in_i[8*n +: 8], data_k_in_i[n], rd);
                w_sym[10*n +: 10] = e[9:0];
                rd = e[10];
            end
        end
        w_rd = rd;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_rd    <= 1'b0;
        end else begin
            r_valid <= data_valid_i;
            if (data_valid_i) begin
                r_sym <= w_sym;
                r_rd  <= w_rd;
            end
        end
    end

    assign data_valid_o = r_valid;
    assign symbols_o    = r_sym;
    assign disparity_o  = r_rd;

`ifdef GEN1_8B10B_KCHECK_EN
    logic w_err;
    logic r_err;

    always_comb begin
        w_err = 1'b0;
        for (int n = 0; n < 4; n++)
            w_err = w_err | (w_act[n] && data_k_in_i[n] && !k_legal(data_in_i[8*n +: 8]));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_err <= 1'b0;
        else if (data_valid_i)
            r_err <= w_err;
    end

    assign code_err_o = r_err;
`else
    assign code_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_gen1_8b10b_encode.sv
// tb_gen1_8b10b_encode: scoreboard bench for gen1_8b10b_encode with directed and random beats.
module tb_gen1_8b10b_encode;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] data_in_i = '0;
    logic [3:0]  data_k_in_i = '0;
    logic        data_valid_i = 1'b0;
    logic [5:0]  pipe_width_i = 6'd32;
    logic        data_valid_o;
    logic [39:0] symbols_o;
    logic        disparity_o;
    logic        code_err_o;

    gen1_8b10b_encode dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .data_in_i    (data_in_i),
        .data_k_in_i  (data_k_in_i),
        .data_valid_i (data_valid_i),
        .pipe_width_i (pipe_width_i),
        .data_valid_o (data_valid_o),
        .symbols_o    (symbols_o),
        .disparity_o  (disparity_o),
        .code_err_o   (code_err_o)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] DN6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] DP6 [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] DN4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] DP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] KN4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] KP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                         8'hF7, 8'hFB, 8'hFD, 8'hFE};

    int n_chk = 0;
    int n_err = 0;
    logic [42:0] q[$];
    logic        m_rd = 1'b0;
    logic [39:0] m_sym = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic m_legal(input logic [7:0] b);
        foreach (KLIST[i])
            if (KLIST[i] == b)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [10:0] m_enc(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       kk, r1, r2;
        logic [5:0] c6;
        logic [3:0] c4;
        logic [9:0] s;
        x = b[4:0];
        y = b[7:5];
        kk = k && m_legal(b);
        if (kk && x == 5'd28)
            c6 = rd ? 6'b110000 : 6'b001111;
        else
            c6 = rd ? DP6[x] : DN6[x];
        r1 = $countones(c6) > 3 ? 1'b1 : $countones(c6) < 3 ? 1'b0 : rd;
        if (kk)
            c4 = r1 ? KP4[y] : KN4[y];
        else if (y == 3'd7 && ((!r1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                               (r1 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            c4 = r1 ? 4'b1000 : 4'b0111;
        else
            c4 = r1 ? DP4[y] : DN4[y];
        r2 = $countones(c4) > 2 ? 1'b1 : $countones(c4) < 2 ? 1'b0 : r1;
        for (int i = 0; i < 6; i++)
            s[i] = c6[5 - i];
        for (int i = 0; i < 4; i++)
            s[6 + i] = c4[3 - i];
        return {r2, s};
    endfunction

    task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic v, input logic [5:0] w);
        int          nl;
        logic [10:0] e;
        logic [39:0] sy;
        logic        er;
        if (v) begin
            nl = w == 6'd8 ? 1 : w == 6'd16 ? 2 : 4;
            sy = '0;
            er = 1'b0;
            for (int n = 0; n < nl; n++) begin
                e = m_enc(d[8*n +: 8], k[n], m_rd);
                sy[10*n +: 10] = e[9:0];
                m_rd = e[10];
                if (k[n] && !m_legal(d[8*n +: 8]))
                    er = 1'b1;
            end
            m_sym = sy;
`ifdef GEN1_8B10B_KCHECK_EN
            m_err = er;
`else
            m_err = 1'b0;
`endif
        end
        q.push_back({v, m_sym, m_rd, m_err});
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic v, input logic [5:0] w);
        logic [42:0] ex;
        data_in_i = d;
        data_k_in_i = k;
        data_valid_i = v;
        pipe_width_i = w;
        model_beat(d, k, v, w);
        @(posedge clk);
        #1;
        ex = q.pop_front();
        chk("valid", data_valid_o, ex[42]);
        chk("symbols", symbols_o, ex[41:2]);
        chk("disparity", disparity_o, ex[1]);
        chk("code_err", code_err_o, ex[0]);
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        data_valid_i = 1'b0;
        #1;
        chk("rst_valid", data_valid_o, 0);
        chk("rst_symbols", symbols_o, 0);
        chk("rst_disparity", disparity_o, 0);
        chk("rst_code_err", code_err_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        m_rd = 1'b0;
        m_sym = '0;
        m_err = 1'b0;
        q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] alt_sym [3];
        logic [31:0] d;
        logic [3:0]  k;
        logic [5:0]  w;
        alt_sym = '{10'h17C, 10'h283, 10'h17C};
        @(negedge clk);
        do_reset;

        beat(32'hBCBCBCBC, 4'hF, 1'b1, 6'd32);
        chk("k285_x4_symbols", symbols_o, {10'h283, 10'h17C, 10'h283, 10'h17C});
        chk("k285_x4_rd", disparity_o, 0);

        do_reset;
        for (int i = 0; i < 3; i++) begin
            beat(32'h0, 4'h0, 1'b1, 6'd32);
            chk("d00_symbols", symbols_o, {4{10'h0B9}});
            chk("d00_rd", disparity_o, 0);
        end

        for (int i = 0; i < 3; i++) begin
            beat(32'h000000BC, 4'h1, 1'b1, 6'd8);
            chk("w8_symbols", symbols_o, {30'h0, alt_sym[i]});
            chk("w8_rd", disparity_o, (i % 2) == 0);
        end

        do_reset;
        beat(32'h000000BC, 4'h1, 1'b1, 6'd8);
        for (int i = 0; i < 2; i++) begin
            beat(32'h12345678, 4'h0, 1'b0, 6'd8);
            chk("idle_hold", symbols_o, {30'h0, 10'h17C});
            chk("idle_valid", data_valid_o, 0);
        end
        beat(32'h000000BC, 4'h1, 1'b1, 6'd8);
        chk("after_idle", symbols_o, {30'h0, 10'h283});

        do_reset;
        beat(32'h000000BC, 4'h3, 1'b1, 6'd16);
        chk("bad_k_symbols", symbols_o, {20'h0, 10'h346, 10'h17C});
`ifdef GEN1_8B10B_KCHECK_EN
        chk("bad_k_err", code_err_o, 1);
`else
        chk("bad_k_err", code_err_o, 0);
`endif

        do_reset;
        beat(32'h000000BC, 4'h1, 1'b1, 6'd8);
        chk("pre_rst_rd", disparity_o, 1);
        #2;
        do_reset;
        beat(32'h000000BC, 4'h1, 1'b1, 6'd8);
        chk("post_rst_sym", symbols_o, {30'h0, 10'h17C});

        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            k = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            for (int n = 0; n < 4; n++)
                if (k[n] && $urandom_range(0, 3) != 0)
                    d[8*n +: 8] = KLIST[$urandom_range(0, 11)];
            case ($urandom_range(0, 4))
                0: w = 6'd8;
                1: w = 6'd16;
                2: w = 6'd32;
                default: w = 6'($urandom);
            endcase
            beat(d, k, $urandom_range(0, 5) != 0, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
